// File: rtl/lut6_cfg_ctrl.sv
// Runtime-programmable LUT6 bank. INIT quarters stream into a shadow bank and are
// copied into the active bank on commit; a registered port evaluates active slots.
module lut6_cfg_ctrl #(
    parameter int          NUM_SLOTS = 4,
    parameter int          SLOT_W    = 2,
    parameter logic [63:0] INIT_RST  = 64'h0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [SLOT_W-1:0]    i_cfg_slot,
    input  logic [15:0]          i_cfg_data,
    input  logic                 i_commit_req,
    output logic                 o_commit_done,
    output logic [NUM_SLOTS-1:0] o_dirty,
    output logic                 o_busy,
    input  logic                 i_ev_valid,
    input  logic [SLOT_W-1:0]    i_ev_slot,
    input  logic [5:0]           i_ev_in,
    output logic                 o_ev_ovalid,
    output logic                 o_ev_o5,
    output logic                 o_ev_o6
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SLOT_W-1:0]     r_slot;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic                  r_pending;
    logic                  w_pending_nxt;
    logic                  w_beat;
    logic                  w_load_done;
    logic                  w_commit;
    logic [SLOT_W-1:0]     w_wr_slot;
    logic                  w_cfg_ready;

    logic [63:0]           r_shadow [NUM_SLOTS];
    logic [63:0]           r_active [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  r_dirty;
    logic                  r_ev_ovalid;
    logic                  r_ev_o5;
    logic                  r_ev_o6;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_pending <= 1'b0;
            r_slot    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            if (r_state == ST_IDLE && i_cfg_valid)
                r_slot <= i_cfg_slot;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_cfg_ready   = 1'b0;
        w_beat        = 1'b0;
        w_load_done   = 1'b0;
        w_commit      = 1'b0;
        w_wr_slot     = r_slot;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                w_wr_slot   = i_cfg_slot;
                if (i_cfg_valid) begin
                    // beat wins over a simultaneous commit; the commit waits as pending
                    w_beat      = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = 2'd1;
                    if (i_commit_req)
                        w_pending_nxt = 1'b1;
                end else if (i_commit_req || r_pending) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_LOAD: begin
                w_cfg_ready = 1'b1;
                if (i_commit_req)
                    w_pending_nxt = 1'b1;
                if (i_cfg_valid) begin
                    w_beat    = 1'b1;
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_load_done = 1'b1;
                        w_state_nxt = (r_pending || i_commit_req) ? ST_COMMIT : ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                w_commit      = 1'b1;
                w_pending_nxt = 1'b0;
                w_cnt_nxt     = 2'd0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = 2'd0;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // Shadow/active banks and dirty tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i] <= INIT_RST;
                r_active[i] <= INIT_RST;
            end
            r_dirty <= '0;
        end else begin
            if (w_beat)
                r_shadow[w_wr_slot][{r_cnt, 4'b0000} +: 16] <= i_cfg_data;
            if (w_commit) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (r_dirty[i])
                        r_active[i] <= r_shadow[i];
                end
                r_dirty <= '0;
            end else if (w_load_done) begin
                r_dirty[r_slot] <= 1'b1;
            end
        end
    end

    // Evaluation reads the pre-edge active bank, so a read in the commit cycle sees old content
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ev_ovalid <= 1'b0;
            r_ev_o5     <= 1'b0;
            r_ev_o6     <= 1'b0;
        end else begin
            r_ev_ovalid <= i_ev_valid;
            if (i_ev_valid) begin
                r_ev_o6 <= r_active[i_ev_slot][i_ev_in];
                r_ev_o5 <= r_active[i_ev_slot][{1'b0, i_ev_in[4:0]}];
            end
        end
    end

    assign o_cfg_ready   = w_cfg_ready;
    assign o_commit_done = (r_state == ST_COMMIT);
    assign o_dirty       = r_dirty;
    assign o_busy        = (r_state != ST_IDLE) || r_pending;
    assign o_ev_ovalid   = r_ev_ovalid;
    assign o_ev_o5       = r_ev_o5;
    assign o_ev_o6       = r_ev_o6;

endmodule

// File: tb/tb_lut6_cfg_ctrl.sv
// Directed bench for lut6_cfg_ctrl: load/commit sequencing, commit/eval ordering,
// reset during load, and a full INIT sweep of every slot.
module tb_lut6_cfg_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_slot;
    logic [15:0] cfg_data;
    logic        commit_req;
    logic        commit_done;
    logic [3:0]  dirty;
    logic        busy;
    logic        ev_valid;
    logic [1:0]  ev_slot;
    logic [5:0]  ev_in;
    logic        ev_ovalid;
    logic        ev_o5;
    logic        ev_o6;

    int n_assert = 0;
    int n_fail   = 0;

    lut6_cfg_ctrl #(
        .NUM_SLOTS (4),
        .SLOT_W    (2),
        .INIT_RST  (64'h0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_slot    (cfg_slot),
        .i_cfg_data    (cfg_data),
        .i_commit_req  (commit_req),
        .o_commit_done (commit_done),
        .o_dirty       (dirty),
        .o_busy        (busy),
        .i_ev_valid    (ev_valid),
        .i_ev_slot     (ev_slot),
        .i_ev_in       (ev_in),
        .o_ev_ovalid   (ev_ovalid),
        .o_ev_o5       (ev_o5),
        .o_ev_o6       (ev_o6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] slot, input logic [15:0] data, input logic creq);
        cfg_valid  = 1'b1;
        cfg_slot   = slot;
        cfg_data   = data;
        commit_req = creq;
        tick();
        cfg_valid  = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic eval(input logic [1:0] slot, input logic [5:0] idx);
        ev_valid = 1'b1;
        ev_slot  = slot;
        ev_in    = idx;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic load4(input logic [1:0] slot, input logic [63:0] v);
        beat(slot, v[15:0], 1'b0);
        beat(slot, v[31:16], 1'b0);
        beat(slot, v[47:32], 1'b0);
        beat(slot, v[63:48], 1'b0);
    endtask

    logic [63:0] k_pat;

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_slot   = 2'd0;
        cfg_data   = 16'h0;
        commit_req = 1'b0;
        ev_valid   = 1'b0;
        ev_slot    = 2'd0;
        ev_in      = 6'd0;
        k_pat      = 64'h0123_4567_89AB_CDEF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1'b1));
        chk("rst_commit_done", 64'(commit_done), 64'(1'b0));
        chk("rst_dirty", 64'(dirty), 64'(4'b0000));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_ev_ovalid", 64'(ev_ovalid), 64'(1'b0));
        chk("rst_ev_o5", 64'(ev_o5), 64'(1'b0));
        chk("rst_ev_o6", 64'(ev_o6), 64'(1'b0));
        rst = 1'b0;
        tick();

        // Slot 1 load, commit, evaluate
        beat(2'd1, 16'hCA00, 1'b0);
        chk("load_busy", 64'(busy), 64'(1'b1));
        beat(2'd1, 16'h0000, 1'b0);
        beat(2'd1, 16'h00FF, 1'b0);
        beat(2'd1, 16'hFFFF, 1'b0);
        chk("s1_dirty", 64'(dirty), 64'(4'b0010));
        chk("s1_idle_busy", 64'(busy), 64'(1'b0));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("s1_commit_done", 64'(commit_done), 64'(1'b1));
        chk("s1_commit_ready", 64'(cfg_ready), 64'(1'b0));
        chk("s1_commit_busy", 64'(busy), 64'(1'b1));
        tick();
        chk("s1_done_low", 64'(commit_done), 64'(1'b0));
        chk("s1_dirty_clr", 64'(dirty), 64'(4'b0000));
        eval(2'd1, 6'b001111);
        chk("s1_i15_ovalid", 64'(ev_ovalid), 64'(1'b1));
        chk("s1_i15_o6", 64'(ev_o6), 64'(1'b1));
        chk("s1_i15_o5", 64'(ev_o5), 64'(1'b1));
        eval(2'd1, 6'b100000);
        chk("s1_i32_o6", 64'(ev_o6), 64'(1'b1));
        chk("s1_i32_o5", 64'(ev_o5), 64'(1'b0));
        tick();
        chk("ev_ovalid_drop", 64'(ev_ovalid), 64'(1'b0));
        chk("ev_o6_hold", 64'(ev_o6), 64'(1'b1));

        // Slot 2 loaded, not committed: shadow invisible
        load4(2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("s2_dirty", 64'(dirty), 64'(4'b0100));
        chk("s2_busy", 64'(busy), 64'(1'b0));
        eval(2'd2, 6'd5);
        chk("s2_uncommitted_o6", 64'(ev_o6), 64'(1'b0));
        chk("s2_uncommitted_o5", 64'(ev_o5), 64'(1'b0));

        // Reload slot 2 with commit_req on beat 2 and a 3-cycle gap
        beat(2'd2, 16'hDEF0, 1'b0);
        beat(2'd2, 16'h9ABC, 1'b1);
        chk("pend_busy", 64'(busy), 64'(1'b1));
        repeat (3) begin
            tick();
            chk("gap_ready", 64'(cfg_ready), 64'(1'b1));
            chk("gap_done", 64'(commit_done), 64'(1'b0));
        end
        beat(2'd2, 16'h5678, 1'b0);
        chk("b3_done", 64'(commit_done), 64'(1'b0));
        beat(2'd2, 16'h1234, 1'b0);
        chk("b4_commit_done", 64'(commit_done), 64'(1'b1));
        chk("b4_dirty", 64'(dirty), 64'(4'b0100));
        chk("b4_ready", 64'(cfg_ready), 64'(1'b0));
        // Evaluate in the commit cycle: old content (zero)
        eval(2'd2, 6'd4);
        chk("commit_cyc_o6_old", 64'(ev_o6), 64'(1'b0));
        chk("commit_cyc_o5_old", 64'(ev_o5), 64'(1'b0));
        chk("post_commit_done", 64'(commit_done), 64'(1'b0));
        chk("post_commit_dirty", 64'(dirty), 64'(4'b0000));
        chk("post_commit_busy", 64'(busy), 64'(1'b0));
        eval(2'd2, 6'd4);
        chk("next_cyc_o6_new", 64'(ev_o6), 64'(1'b1));
        chk("next_cyc_o5_new", 64'(ev_o5), 64'(1'b1));
        eval(2'd2, 6'd63);
        chk("s2_i63_o6", 64'(ev_o6), 64'(1'b0));
        chk("s2_i63_o5", 64'(ev_o5), 64'(1'b1));

        // Reset mid-load discards the partial load
        beat(2'd3, 16'hFFFF, 1'b0);
        beat(2'd3, 16'hFFFF, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_ready", 64'(cfg_ready), 64'(1'b1));
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_ovalid", 64'(ev_ovalid), 64'(1'b0));
        rst = 1'b0;
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("rst_commit_done", 64'(commit_done), 64'(1'b1));
        chk("rst_commit_dirty", 64'(dirty), 64'(4'b0000));
        tick();
        eval(2'd3, 6'd0);
        chk("s3_i0_o6", 64'(ev_o6), 64'(1'b0));
        eval(2'd3, 6'd63);
        chk("s3_i63_o6", 64'(ev_o6), 64'(1'b0));
        eval(2'd2, 6'd4);
        chk("s2_after_rst_o6", 64'(ev_o6), 64'(1'b0));

        // Load every slot, single commit, full sweep
        load4(2'd0, k_pat);
        load4(2'd1, k_pat);
        load4(2'd2, k_pat);
        load4(2'd3, k_pat);
        chk("all_dirty", 64'(dirty), 64'(4'b1111));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("all_commit_done", 64'(commit_done), 64'(1'b1));
        tick();
        chk("all_dirty_clr", 64'(dirty), 64'(4'b0000));
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 64; k++) begin
                eval(2'(s), 6'(k));
                chk($sformatf("sweep_o6_s%0d_i%0d", s, k), 64'(ev_o6), 64'(k_pat[k]));
                chk($sformatf("sweep_o5_s%0d_i%0d", s, k), 64'(ev_o5), 64'(k_pat[k % 32]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
